// File: rtl/weight_bram_ctrl.sv
// Weight buffer controller: fills a simple dual-port weight BRAM from the
// AXI-Stream weight channel and serves adjacent word pairs to the MAC preload
// path under strobes from the layer control unit.
// Optional build macro: WEIGHT_BRAM_CHECKSUM_EN adds a running wrapping sum of
// accepted stream beats on weight_checksum; otherwise that port is tied to 0.
module weight_bram_ctrl #(
  parameter int BRAM_ADDRESS_WIDTH   = 12,
  parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  input  logic                            bram_write_en,
  input  logic                            bram_transfer_start,
  input  logic                            bram_control_add1,
  input  logic                            bram_control_add2,
  input  logic                            bram_port_sel,
  output logic                            write_weight_finish,
  output logic                            write_overflow,
  output logic                            weight_from_bram_valid,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] weight_out,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] weight_checksum
);

  localparam int AW    = BRAM_ADDRESS_WIDTH;
  localparam int DW    = C_S_AXIS_TDATA_WIDTH;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    IDLE,
    W_ACTIVE,
    W_DONE,
    R_FETCH,
    R_VALID
  } state_t;

  state_t          state;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   rd_addr_b;
  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   port_a_p1;
  logic [DW-1:0]   port_b_p1;
  logic            tready_q;
  logic            finish_q;
  logic            overflow_q;
  logic            vld_p1;
  logic            beat;

  // A restart takes priority, so a beat coinciding with it is not stored.
  assign beat      = tready_q & s_axis_tvalid & ~bram_transfer_start;
  assign rd_addr_b = rd_addr + AW'(1);

  assign s_axis_tready          = tready_q;
  assign write_weight_finish    = finish_q;
  assign write_overflow         = overflow_q;
  assign weight_from_bram_valid = vld_p1;
  assign weight_out             = bram_port_sel ? port_b_p1 : port_a_p1;

  // Control FSM: transfer sequencing, address counters and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_addr    <= '0;
      rd_addr    <= '0;
      tready_q   <= 1'b0;
      finish_q   <= 1'b0;
      overflow_q <= 1'b0;
      vld_p1     <= 1'b0;
    end else if (bram_transfer_start) begin
      finish_q <= 1'b0;
      vld_p1   <= 1'b0;
      if (bram_write_en) begin
        state      <= W_ACTIVE;
        wr_addr    <= '0;
        overflow_q <= 1'b0;
        tready_q   <= 1'b1;
      end else begin
        state    <= R_FETCH;
        rd_addr  <= '0;
        tready_q <= 1'b0;
      end
    end else begin
      case (state)
        W_ACTIVE: begin
          if (!bram_write_en) begin
            state    <= IDLE;
            tready_q <= 1'b0;
          end else if (beat) begin
            if (s_axis_tlast) begin
              state    <= W_DONE;
              tready_q <= 1'b0;
              finish_q <= 1'b1;
            end else if (wr_addr == {AW{1'b1}}) begin
              // Buffer full without tlast: stop here rather than wrap.
              state      <= W_DONE;
              tready_q   <= 1'b0;
              finish_q   <= 1'b1;
              overflow_q <= 1'b1;
            end else begin
              wr_addr <= wr_addr + AW'(1);
            end
          end
        end
        W_DONE: begin
          if (!bram_write_en) begin
            state    <= IDLE;
            finish_q <= 1'b0;
          end
        end
        R_FETCH: begin
          state  <= R_VALID;
          vld_p1 <= 1'b1;
        end
        R_VALID: begin
          // Dropping valid for the refetch cycle keeps one advance from
          // being seen twice.
          if (bram_control_add2) begin
            rd_addr <= rd_addr + AW'(2);
            state   <= R_FETCH;
            vld_p1  <= 1'b0;
          end else if (bram_control_add1) begin
            rd_addr <= rd_addr + AW'(1);
            state   <= R_FETCH;
            vld_p1  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          tready_q <= 1'b0;
          finish_q <= 1'b0;
          vld_p1   <= 1'b0;
        end
      endcase
    end
  end

  // BRAM write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem[wr_addr] <= s_axis_tdata;
    end
  end

  // Read stage: both ports capture the addressed pair during fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_a_p1 <= '0;
      port_b_p1 <= '0;
    end else if (state == R_FETCH) begin
      port_a_p1 <= mem[rd_addr];
      port_b_p1 <= mem[rd_addr_b];
    end
  end

`ifdef WEIGHT_BRAM_CHECKSUM_EN
  logic [DW-1:0] checksum_q;

  // Running wrapping sum of accepted beats, restarted with each write transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (bram_transfer_start && bram_write_en) begin
      checksum_q <= '0;
    end else if (beat) begin
      checksum_q <= checksum_q + s_axis_tdata;
    end
  end

  assign weight_checksum = checksum_q;
`else
  assign weight_checksum = '0;
`endif

endmodule

// File: tb/tb_weight_bram_ctrl.sv
// Self-checking bench for weight_bram_ctrl (small 16-word buffer).
module tb_weight_bram_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          bram_write_en;
  logic          bram_transfer_start;
  logic          bram_control_add1;
  logic          bram_control_add2;
  logic          bram_port_sel;
  logic          write_weight_finish;
  logic          write_overflow;
  logic          weight_from_bram_valid;
  logic [DW-1:0] weight_out;
  logic [DW-1:0] weight_checksum;

  weight_bram_ctrl #(
    .BRAM_ADDRESS_WIDTH  (AW),
    .C_S_AXIS_TDATA_WIDTH(DW)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .s_axis_tdata          (s_axis_tdata),
    .s_axis_tvalid         (s_axis_tvalid),
    .s_axis_tlast          (s_axis_tlast),
    .s_axis_tready         (s_axis_tready),
    .bram_write_en         (bram_write_en),
    .bram_transfer_start   (bram_transfer_start),
    .bram_control_add1     (bram_control_add1),
    .bram_control_add2     (bram_control_add2),
    .bram_port_sel         (bram_port_sel),
    .write_weight_finish   (write_weight_finish),
    .write_overflow        (write_overflow),
    .weight_from_bram_valid(weight_from_bram_valid),
    .weight_out            (weight_out),
    .weight_checksum       (weight_checksum)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] csum_m;

  typedef struct {
    bit            start;
    bit            a1;
    bit            a2;
    bit            sel;
    bit            exp_vld;
    bit            chk_out;
    logic [DW-1:0] exp_out;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_cs(input logic [DW-1:0] s);
`ifdef WEIGHT_BRAM_CHECKSUM_EN
    return s;
`else
    return (s & '0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write transfer of n random words with random tvalid gaps.
  task automatic wr_burst(input int n, input bit use_last);
    int i;
    int guard;
    i = 0;
    guard = 0;
    bram_write_en = 1'b1;
    bram_transfer_start = 1'b1;
    tick();
    bram_transfer_start = 1'b0;
    csum_m = '0;
    while (i < n && guard < 400) begin
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = $urandom;
      s_axis_tlast  = use_last && (i == n - 1);
      if (s_axis_tvalid) begin
        #1;
        chk("wr_tready", {31'd0, s_axis_tready}, 32'd1);
        mem_m[i] = s_axis_tdata;
        csum_m   = csum_m + s_axis_tdata;
        i++;
      end
      tick();
      guard++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (guard >= 400) chk("wr_timeout", 32'(i), 32'(n));
  endtask

  task automatic rd_start();
    int n;
    n = 0;
    bram_write_en = 1'b0;
    bram_transfer_start = 1'b1;
    tick();
    bram_transfer_start = 1'b0;
    while (!weight_from_bram_valid && n < 8) begin
      tick();
      n++;
    end
    chk("rd_valid_wait", {31'd0, weight_from_bram_valid}, 32'd1);
  endtask

  task automatic chk_pair(input int addr);
    bram_port_sel = 1'b0;
    #1;
    chk("port_a", weight_out, mem_m[addr % DEPTH]);
    bram_port_sel = 1'b1;
    #1;
    chk("port_b", weight_out, mem_m[(addr + 1) % DEPTH]);
    bram_port_sel = 1'b0;
  endtask

  // Advance from R_VALID; optionally pulse a spurious advance during fetch.
  task automatic adv(input bit a1, input bit a2, input bit spurious);
    int n;
    n = 0;
    bram_control_add1 = a1;
    bram_control_add2 = a2;
    tick();
    bram_control_add1 = spurious;
    bram_control_add2 = 1'b0;
    chk("adv_gap", {31'd0, weight_from_bram_valid}, 32'd0);
    tick();
    bram_control_add1 = 1'b0;
    while (!weight_from_bram_valid && n < 8) begin
      tick();
      n++;
    end
    chk("adv_valid", {31'd0, weight_from_bram_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int addr;
    int k;
    rst_n = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    bram_write_en = 1'b0;
    bram_transfer_start = 1'b0;
    bram_control_add1 = 1'b0;
    bram_control_add2 = 1'b0;
    bram_port_sel = 1'b0;
    tick();
    tick();
    chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_finish", {31'd0, write_weight_finish}, 32'd0);
    chk("rst_ovf", {31'd0, write_overflow}, 32'd0);
    chk("rst_valid", {31'd0, weight_from_bram_valid}, 32'd0);
    chk("rst_out", weight_out, 32'd0);
    chk("rst_csum", weight_checksum, 32'd0);
    rst_n = 1'b1;
    tick();

    // Four-word write with tlast on the last word.
    bram_write_en = 1'b1;
    bram_transfer_start = 1'b1;
    tick();
    bram_transfer_start = 1'b0;
    chk("w4_tready", {31'd0, s_axis_tready}, 32'd1);
    csum_m = '0;
    for (int i = 0; i < 4; i++) begin
      s_axis_tdata  = 32'h11 * (i + 1);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == 3);
      mem_m[i] = s_axis_tdata;
      csum_m   = csum_m + s_axis_tdata;
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk("w4_finish", {31'd0, write_weight_finish}, 32'd1);
    chk("w4_tready_low", {31'd0, s_axis_tready}, 32'd0);
    chk("w4_ovf", {31'd0, write_overflow}, 32'd0);
    chk("w4_csum", weight_checksum, exp_cs(32'hAA));
    bram_write_en = 1'b0;
    tick();
    chk("w4_finish_drop", {31'd0, write_weight_finish}, 32'd0);

    // Cycle-by-cycle read-back, port select and add2 table.
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 32'h0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 32'h0};
    tbl[2]  = '{0, 1, 0, 0, 1, 1, 32'h11};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 32'h0};
    tbl[4]  = '{0, 1, 0, 0, 1, 1, 32'h22};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 32'h0};
    tbl[6]  = '{0, 1, 0, 0, 1, 1, 32'h33};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 32'h0};
    tbl[8]  = '{0, 0, 0, 0, 1, 1, 32'h44};
    tbl[9]  = '{1, 0, 0, 0, 1, 0, 32'h0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 32'h0};
    tbl[11] = '{0, 0, 0, 0, 1, 1, 32'h11};
    tbl[12] = '{0, 0, 1, 1, 1, 1, 32'h22};
    tbl[13] = '{0, 1, 0, 0, 0, 0, 32'h0};
    tbl[14] = '{0, 0, 0, 0, 1, 1, 32'h33};
    tbl[15] = '{0, 0, 0, 1, 1, 1, 32'h44};
    for (int i = 0; i < 16; i++) begin
      bram_transfer_start = tbl[i].start;
      bram_control_add1   = tbl[i].a1;
      bram_control_add2   = tbl[i].a2;
      bram_port_sel       = tbl[i].sel;
      #1;
      chk($sformatf("tbl%0d_valid", i), {31'd0, weight_from_bram_valid}, {31'd0, tbl[i].exp_vld});
      if (tbl[i].chk_out) chk($sformatf("tbl%0d_out", i), weight_out, tbl[i].exp_out);
      tick();
    end
    bram_transfer_start = 1'b0;
    bram_control_add1 = 1'b0;
    bram_control_add2 = 1'b0;
    bram_port_sel = 1'b0;

    // Overflow: fill every word without tlast, then offer one extra beat.
    wr_burst(DEPTH, 1'b0);
    chk("ovf_flag", {31'd0, write_overflow}, 32'd1);
    chk("ovf_finish", {31'd0, write_weight_finish}, 32'd1);
    chk("ovf_tready", {31'd0, s_axis_tready}, 32'd0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hDEAD_BEEF;
    tick();
    s_axis_tvalid = 1'b0;
    chk("ovf_csum", weight_checksum, exp_cs(csum_m));
    bram_write_en = 1'b0;
    tick();

    // Wrap: walk to the last word, then add1+add2 together wraps to 1.
    rd_start();
    chk_pair(0);
    for (int i = 0; i < 7; i++) adv(1'b0, 1'b1, 1'b0);
    chk_pair(14);
    adv(1'b1, 1'b0, 1'b0);
    chk_pair(15);
    adv(1'b1, 1'b1, 1'b1);
    chk_pair(1);

    // Reset mid-write after two beats, then rewrite from address 0.
    bram_write_en = 1'b1;
    bram_transfer_start = 1'b1;
    tick();
    bram_transfer_start = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'hA5A5_0001;
    tick();
    s_axis_tdata = 32'hA5A5_0002;
    tick();
    s_axis_tdata = 32'hA5A5_0003;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("mrst_finish", {31'd0, write_weight_finish}, 32'd0);
    chk("mrst_ovf", {31'd0, write_overflow}, 32'd0);
    chk("mrst_out", weight_out, 32'd0);
    chk("mrst_csum", weight_checksum, 32'd0);
    s_axis_tvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bram_transfer_start = 1'b1;
    tick();
    bram_transfer_start = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'h0A0;
    tick();
    s_axis_tdata = 32'h0B0;
    s_axis_tlast = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    mem_m[0] = 32'h0A0;
    mem_m[1] = 32'h0B0;
    chk("mrst_rewrite_finish", {31'd0, write_weight_finish}, 32'd1);
    chk("mrst_rewrite_csum", weight_checksum, exp_cs(32'h150));
    bram_write_en = 1'b0;
    tick();
    rd_start();
    chk_pair(0);

    // Randomized writes and reads against the array model.
    for (int it = 0; it < 6; it++) begin
      wr_burst($urandom_range(1, DEPTH), 1'b1);
      chk("rnd_finish", {31'd0, write_weight_finish}, 32'd1);
      chk("rnd_ovf", {31'd0, write_overflow}, 32'd0);
      chk("rnd_csum", weight_checksum, exp_cs(csum_m));
      bram_write_en = 1'b0;
      tick();
      rd_start();
      addr = 0;
      for (int j = 0; j < 12; j++) begin
        chk_pair(addr);
        k = $urandom_range(1, 3);
        adv(k[0], k[1], 1'($urandom_range(0, 1)));
        addr = (addr + (k[1] ? 2 : 1)) % DEPTH;
      end
      chk_pair(addr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_bram_ctrl.md
# weight_bram_ctrl

Weight buffer controller sitting directly below the layer control unit. It owns a simple dual-port weight BRAM, fills it from the AXI-Stream weight channel during a write-weight instruction, and serves weights back to the MAC preload path during compute under the control unit's `bram_transfer_start`/`bram_control_add1`/`bram_control_add2`/`bram_port_sel` strobes. It returns `write_weight_finish` and `weight_from_bram_valid` to the control unit.

## Interface
- `BRAM_ADDRESS_WIDTH`, 12: word address width; depth = 2^BRAM_ADDRESS_WIDTH.
- `C_S_AXIS_TDATA_WIDTH`, 32: weight word and stream data width.

Ports:
- `clk` in 1: single clock. All logic is synchronous to `clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in C_S_AXIS_TDATA_WIDTH: weight stream data.
- `s_axis_tvalid` in 1: stream valid.
- `s_axis_tlast` in 1: last weight word of the transfer.
- `s_axis_tready` out 1: stream ready.
- `bram_write_en` in 1: write-weight instruction active.
- `bram_transfer_start` in 1: one-cycle pulse that restarts the current transfer at address 0.
- `bram_control_add1` in 1: advance the read address by 1.
- `bram_control_add2` in 1: advance the read address by 2.
- `bram_port_sel` in 1: output mux select; 0 selects port A (addr), 1 selects port B (addr+1).
- `write_weight_finish` out 1: write transfer complete; held high.
- `write_overflow` out 1: sticky flag; the buffer filled before `tlast`.
- `weight_from_bram_valid` out 1: `weight_out` holds fresh data.
- `weight_out` out C_S_AXIS_TDATA_WIDTH: selected weight word.
- `weight_checksum` out C_S_AXIS_TDATA_WIDTH: see Configuration.

## Operation
- FSM states: IDLE, W_ACTIVE, W_DONE, R_FETCH, R_VALID.
- Transfer start, from any state:
  - `bram_transfer_start` with `bram_write_en`=1: go to W_ACTIVE, set wr_addr=0, clear `write_overflow`.
  - `bram_transfer_start` with `bram_write_en`=0: go to R_FETCH, set rd_addr=0.
  - `bram_transfer_start` has priority over every other event.
- W_ACTIVE: `s_axis_tready`=1. Each beat with valid&ready writes mem[wr_addr] and increments wr_addr.
  - Beat with `tlast`: go to W_DONE.
  - Beat at wr_addr = 2^AW−1 without `tlast`: set `write_overflow`, go to W_DONE. The address does not wrap.
- W_DONE: `write_weight_finish`=1 and `s_axis_tready`=0.
- Leaving write mode: `bram_write_en` low in W_ACTIVE or W_DONE returns to IDLE at the next edge. A transfer dropped before completion leaves partial contents and no error flag.
- R_FETCH: both ports read at rd_addr and rd_addr+1 (mod 2^AW); data is registered. Next state is R_VALID.
- R_VALID: `weight_from_bram_valid`=1, data held stable. Advances:
  - `add2` adds 2 to rd_addr; `add1` adds 1.
  - If both are asserted, `add2` wins.
  - Either advance returns to R_FETCH.
- Advance pulses outside R_VALID are ignored.
- rd_addr is modulo 2^AW, so 2^AW−1 + 1 wraps to 0.
- `weight_out` = `bram_port_sel` ? regB : regA. This mux is combinational, so a port switch takes effect in the same cycle.
- Memory contents are not reset.
- Reset values: state IDLE, addresses 0, `s_axis_tready`=0, `write_weight_finish`=0, `write_overflow`=0, `weight_from_bram_valid`=0, `weight_out`=0, `weight_checksum`=0.
- Reset mid-transfer aborts the transfer immediately.

## Timing
- Read latency: `bram_transfer_start` in cycle t gives valid=1 in cycle t+2.
- Advance turnaround: an advance in cycle t gives valid=0 in t+1 and valid=1 with new data in t+2. Valid is never high for two consecutive cycles across an advance, so one advance is never counted twice.
- Write throughput: one word per cycle.
- `write_weight_finish` rises in the cycle after the `tlast` beat.
- A read of an address written in the same cycle returns the old data.

## Configuration
- `WEIGHT_BRAM_CHECKSUM_EN` defined:
  - `weight_checksum` is a wrapping C_S_AXIS_TDATA_WIDTH-bit sum of all accepted beats.
  - It is cleared by a write-mode `bram_transfer_start` and updated one cycle after each beat.
- `WEIGHT_BRAM_CHECKSUM_EN` undefined: `weight_checksum` is tied to 0 and no adder is built.

## Test plan
- Write 4 words 0x11,0x22,0x33,0x44 with `tlast` on the 4th -> finish=1 in the next cycle, tready=0, checksum=0xAA (checksum enabled).
- Read-back with start then `add1` on each valid -> `weight_out` 0x11,0x22,0x33,0x44; valid pattern 0,0,1,0,1,0,1,0,1.
- In R_VALID at rd_addr=0, `port_sel`=1 -> 0x22 in the same cycle; `add2` -> next valid shows 0x33 (port A) and 0x44 (port B).
- Write 2^AW words with no `tlast` -> overflow=1, finish=1; 1 extra beat is not accepted.
- `add1` and `add2` asserted together at rd_addr=2^AW−1 -> rd_addr wraps to 1; an advance during R_FETCH is ignored.
- `rst_n` pulsed low mid-write after 2 beats -> all outputs 0 immediately; a new start rewrites from address 0.
